// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA colour-path controller.
//   H_ACTIVE / V_ACTIVE : visible raster size of the 640x480 timing
//   BAR_W               : default test-pattern bar width in pixels
//   state_t             : commit FSM encoding (IDLE, WAIT_BLANK, COMMIT)
//   BLACK / WHITE       : named colour constants for the 3-bit {R,G,B} bus
// No ports; imported by every file of the colour path.
// ---------------------------------------------------------------------------
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int BAR_W    = 80;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_BLANK = 2'd1,
      COMMIT     = 2'd2
   } state_t;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;

endpackage

// File: rtl/vga_color_ctrl_if.sv
// ---------------------------------------------------------------------------
// vga_color_ctrl_if
// Bundles the raster timing, switch inputs and status/colour outputs of the
// colour controller.
//   pixel_x[9:0], pixel_y[8:0], video_on, v_sync : timing generator -> ctrl
//   swcolors[2:0], pattern_en                    : raw board switches -> ctrl
//   colors_out[2:0]                              : registered pixel colour
//   color_cfg[2:0], pattern_active, cfg_pending  : committed config / status
//   frame_cnt[7:0]                               : frame counter
// Modport slave is the controller's view, master is the driver's view.
// ---------------------------------------------------------------------------
interface vga_color_ctrl_if;
   import vga_pkg::*;

   logic [9:0] pixel_x;
   logic [8:0] pixel_y;
   logic       video_on;
   logic       v_sync;
   logic [2:0] swcolors;
   logic       pattern_en;
   logic [2:0] colors_out;
   logic [2:0] color_cfg;
   logic       pattern_active;
   logic       cfg_pending;
   logic [7:0] frame_cnt;

   modport master (
      output pixel_x, pixel_y, video_on, v_sync, swcolors, pattern_en,
      input  colors_out, color_cfg, pattern_active, cfg_pending, frame_cnt
   );

   modport slave (
      input  pixel_x, pixel_y, video_on, v_sync, swcolors, pattern_en,
      output colors_out, color_cfg, pattern_active, cfg_pending, frame_cnt
   );

endinterface

// File: rtl/vga_color_ctrl_sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
// Two-flop synchroniser followed by a shared stability counter for a small
// bus of asynchronous switches.
//   clk, reset     : clock and synchronous active-high reset
//   i_raw[W-1:0]   : raw asynchronous switch bus
//   o_syn[W-1:0]   : synchronised switch value (output of the 2-flop chain)
//   o_sample[W-1:0]: last synchronised value the counter is timing
//   o_stable       : o_sample has held for DEB_CYCLES consecutive samples
// ---------------------------------------------------------------------------
module sw_debounce
   import vga_pkg::*;
#(
   parameter int          WIDTH      = 4,
   parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_raw,
   output logic [WIDTH-1:0] o_syn,
   output logic [WIDTH-1:0] o_sample,
   output logic             o_stable
);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_sample;
   logic [15:0]      r_cnt;

   // Any change in the synchronised value restarts the count; otherwise the
   // counter climbs and parks at its terminal value so stable stays high
   // for as long as the switches do not move.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_sample <= '0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_sample) begin
            r_sample <= r_sync2;
            r_cnt    <= '0;
         end else if (r_cnt != DEB_CYCLES - 16'd1) begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

   assign o_syn    = r_sync2;
   assign o_sample = r_sample;
   assign o_stable = (r_cnt == DEB_CYCLES - 16'd1);

endmodule

// File: rtl/vga_color_ctrl.sv
// ---------------------------------------------------------------------------
// vga_color_ctrl
// Colour-path configuration controller for the 640x480 VGA datapath.
// Debounces the colour/pattern switches, commits a new setting only on a
// v_sync falling edge so the picture never tears, counts frames and drives
// the registered pixel colour (solid colour or 8 vertical bars).
//   clk, reset : clock and synchronous active-high reset
//   bus        : vga_color_ctrl_if.slave (timing in, switches in, colour and
//                status out)
// ---------------------------------------------------------------------------
module vga_color_ctrl
   import vga_pkg::*;
#(
   parameter logic [15:0] DEB_CYCLES  = 16'd50000,
   parameter logic [2:0]  RESET_COLOR = 3'b000,
   parameter int          BAR_W       = 80
) (
   input  logic              clk,
   input  logic              reset,
   vga_color_ctrl_if.slave   bus
);

   state_t     r_state;
   logic [2:0] r_colorCfg;
   logic       r_patternActive;
   logic       r_cfgPending;
   logic [2:0] r_colorsOut;
   logic [7:0] r_frameCnt;
   logic       r_vSyncD;

   logic [3:0] w_syn;
   logic [3:0] w_sample;
   logic       w_stable;
   logic       w_fe;
   logic [2:0] w_bar;
   logic       w_unusedPixelY;

   // Row is carried for completeness only; nothing here depends on it.
   assign w_unusedPixelY = ^bus.pixel_y;

   // Pattern request and colour share one debounce counter so a setting is
   // only considered once the whole switch bank has settled.
   sw_debounce #(
      .WIDTH      (4),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .i_raw    ({bus.pattern_en, bus.swcolors}),
      .o_syn    (w_syn),
      .o_sample (w_sample),
      .o_stable (w_stable)
   );

   // Falling edge of the active-low v_sync marks the frame boundary; the
   // delayed copy resets high so a low v_sync at release is not a false edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vSyncD   <= 1'b1;
         r_frameCnt <= '0;
      end else begin
         r_vSyncD <= bus.v_sync;
         if (w_fe) begin
            r_frameCnt <= r_frameCnt + 8'd1;
         end
      end
   end

   assign w_fe = r_vSyncD & ~bus.v_sync;

   // Commit sequencer. A stable setting that differs from the committed one
   // waits for the next frame edge; if the switches move meanwhile the wait
   // is abandoned, even when the edge arrives in that same cycle, and the new
   // value must settle again. cfg_pending mirrors "in WAIT_BLANK".
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= IDLE;
         r_colorCfg      <= RESET_COLOR;
         r_patternActive <= 1'b0;
         r_cfgPending    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_stable && (w_sample != {r_patternActive, r_colorCfg})) begin
                  r_state      <= WAIT_BLANK;
                  r_cfgPending <= 1'b1;
               end
            end
            WAIT_BLANK: begin
               if (w_syn != w_sample) begin
                  r_state      <= IDLE;
                  r_cfgPending <= 1'b0;
               end else if (w_fe) begin
                  r_state      <= COMMIT;
                  r_cfgPending <= 1'b0;
               end
            end
            COMMIT: begin
               {r_patternActive, r_colorCfg} <= w_sample;
               r_state                       <= IDLE;
            end
            default: begin
               r_state      <= IDLE;
               r_cfgPending <= 1'b0;
            end
         endcase
      end
   end

   // Bar index from a comparator chain against multiples of BAR_W; anything
   // at or past the seventh boundary, including off-screen columns, is bar 7.
   always_comb begin
      w_bar = 3'd7;
      for (int i = 6; i >= 0; i--) begin
         if (bus.pixel_x < 10'((i + 1) * BAR_W)) begin
            w_bar = 3'(i);
         end
      end
   end

   // Pixel colour register: blanking forces black, otherwise bars or the
   // committed solid colour.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_colorsOut <= BLACK;
      end else if (!bus.video_on) begin
         r_colorsOut <= BLACK;
      end else if (r_patternActive) begin
         r_colorsOut <= w_bar;
      end else begin
         r_colorsOut <= r_colorCfg;
      end
   end

   assign bus.colors_out     = r_colorsOut;
   assign bus.color_cfg      = r_colorCfg;
   assign bus.pattern_active = r_patternActive;
   assign bus.cfg_pending    = r_cfgPending;
   assign bus.frame_cnt      = r_frameCnt;

endmodule

// File: tb/tb_vga_color_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_color_ctrl
// Self-checking bench for vga_color_ctrl with a short debounce window
// (DEB_CYCLES=4) and a non-zero reset colour (3'b010).
// ---------------------------------------------------------------------------
module tb_vga_color_ctrl;
   import vga_pkg::*;

   typedef struct {
      logic [9:0] x;
      logic       vid;
      logic [2:0] expColor;
   } barVec_t;

   logic clk;
   logic reset;
   int   testsRun;
   int   testsFailed;
   logic [7:0] expFrames;

   vga_color_ctrl_if bus();

   vga_color_ctrl #(
      .DEB_CYCLES  (16'd4),
      .RESET_COLOR (3'b010),
      .BAR_W       (80)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a sequence stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // One clock edge, then settle away from it for driving and sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [9:0] x, input logic vid);
      bus.pixel_x  = x;
      bus.video_on = vid;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bounded wait for cfg_pending to rise
   task automatic waitPending(input string name);
      int n;
      n = 0;
      while (bus.cfg_pending !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checkOutput(name, 8'(bus.cfg_pending), 8'd1);
   endtask

   // One-cycle-low v_sync pulse: frame edge on the first tick, any commit
   // lands on the second
   task automatic vsyncPulse();
      bus.v_sync = 1'b0;
      tick();
      bus.v_sync = 1'b1;
      tick();
      expFrames = expFrames + 8'd1;
   endtask

   initial begin
      barVec_t vecs [14];
      testsRun    = 0;
      testsFailed = 0;
      expFrames   = 8'd0;

      vecs[0]  = '{10'd0,   1'b1, 3'd0};
      vecs[1]  = '{10'd79,  1'b1, 3'd0};
      vecs[2]  = '{10'd80,  1'b1, 3'd1};
      vecs[3]  = '{10'd159, 1'b1, 3'd1};
      vecs[4]  = '{10'd160, 1'b1, 3'd2};
      vecs[5]  = '{10'd240, 1'b1, 3'd3};
      vecs[6]  = '{10'd320, 1'b0, 3'd0};
      vecs[7]  = '{10'd320, 1'b1, 3'd4};
      vecs[8]  = '{10'd400, 1'b1, 3'd5};
      vecs[9]  = '{10'd559, 1'b1, 3'd6};
      vecs[10] = '{10'd560, 1'b1, 3'd7};
      vecs[11] = '{10'd639, 1'b1, 3'd7};
      vecs[12] = '{10'd700, 1'b1, 3'd7};
      vecs[13] = '{10'd100, 1'b0, 3'd0};

      reset          = 1'b1;
      bus.pixel_x    = 10'd0;
      bus.pixel_y    = 9'd0;
      bus.video_on   = 1'b1;
      bus.v_sync     = 1'b1;
      bus.swcolors   = 3'b000;
      bus.pattern_en = 1'b0;

      // Reset state
      tick(); tick(); tick();
      checkOutput("rst_colors_out", 8'(bus.colors_out), 8'd0);
      checkOutput("rst_color_cfg", 8'(bus.color_cfg), 8'h02);
      checkOutput("rst_pending", 8'(bus.cfg_pending), 8'd0);
      checkOutput("rst_frame_cnt", bus.frame_cnt, 8'd0);
      reset = 1'b0;
      tick();
      checkOutput("post_rst_colors_out", 8'(bus.colors_out), 8'h02);
      checkOutput("post_rst_pending", 8'(bus.cfg_pending), 8'd0);
      checkOutput("post_rst_frame_cnt", bus.frame_cnt, 8'd0);

      // Switches at 000 differ from the reset colour: commit them first
      waitPending("pend_000");
      vsyncPulse();
      checkOutput("commit_000", 8'(bus.color_cfg), 8'd0);

      // 000 -> 101: pending exactly 7 edges after the switch change
      bus.swcolors = 3'b101;
      for (int i = 0; i < 6; i++) tick();
      checkOutput("pend_101_early", 8'(bus.cfg_pending), 8'd0);
      tick();
      checkOutput("pend_101_rise", 8'(bus.cfg_pending), 8'd1);
      tick(); tick(); tick();
      checkOutput("pend_101_hold", 8'(bus.cfg_pending), 8'd1);
      checkOutput("cfg_101_not_yet", 8'(bus.color_cfg), 8'd0);
      bus.v_sync = 1'b0;
      tick();
      expFrames = expFrames + 8'd1;
      checkOutput("commit_state_pending", 8'(bus.cfg_pending), 8'd0);
      checkOutput("commit_state_cfg", 8'(bus.color_cfg), 8'd0);
      checkOutput("frame_cnt_2", bus.frame_cnt, expFrames);
      bus.v_sync = 1'b1;
      tick();
      checkOutput("cfg_101", 8'(bus.color_cfg), 8'h05);
      tick();
      checkOutput("colors_101", 8'(bus.colors_out), 8'h05);

      // Bouncing switches across three frames never commit
      for (int cyc = 0; cyc < 30; cyc++) begin
         bus.swcolors = ((cyc / 2) % 2 == 0) ? 3'b101 : 3'b011;
         bus.v_sync   = (cyc % 10 == 5) ? 1'b0 : 1'b1;
         if (cyc % 10 == 5) expFrames = expFrames + 8'd1;
         tick();
         checkOutput("bounce_pending", 8'(bus.cfg_pending), 8'd0);
      end
      bus.v_sync = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      checkOutput("bounce_cfg", 8'(bus.color_cfg), 8'h05);
      checkOutput("bounce_frames", bus.frame_cnt, expFrames);

      // Switch move coinciding with the frame edge abandons the commit
      bus.swcolors = 3'b011;
      waitPending("pend_011");
      bus.swcolors = 3'b110;
      tick(); tick();
      bus.v_sync = 1'b0;
      tick();
      expFrames = expFrames + 8'd1;
      checkOutput("abandon_pending", 8'(bus.cfg_pending), 8'd0);
      bus.v_sync = 1'b1;
      tick();
      checkOutput("abandon_cfg", 8'(bus.color_cfg), 8'h05);
      waitPending("pend_110");
      vsyncPulse();
      checkOutput("commit_110", 8'(bus.color_cfg), 8'h06);
      checkOutput("commit_110_pending", 8'(bus.cfg_pending), 8'd0);

      // Commit pattern mode, then sweep the bar table
      bus.pattern_en = 1'b1;
      waitPending("pend_pattern");
      vsyncPulse();
      checkOutput("pattern_active", 8'(bus.pattern_active), 8'd1);
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].x, vecs[i].vid);
         tick();
         checkOutput($sformatf("bar_vec%0d", i), 8'(bus.colors_out), 8'(vecs[i].expColor));
      end
      applyStimulus(10'd0, 1'b1);

      // Frame counter wrap
      for (int n = 0; n < 300 && expFrames != 8'd255; n++) vsyncPulse();
      checkOutput("frame_cnt_255", bus.frame_cnt, 8'd255);
      vsyncPulse();
      checkOutput("frame_cnt_wrap", bus.frame_cnt, 8'd0);

      // Reset while a setting is pending discards it
      bus.pattern_en = 1'b0;
      bus.swcolors   = 3'b111;
      waitPending("pend_111");
      reset = 1'b1;
      tick();
      checkOutput("midrst_pending", 8'(bus.cfg_pending), 8'd0);
      checkOutput("midrst_cfg", 8'(bus.color_cfg), 8'h02);
      checkOutput("midrst_pattern", 8'(bus.pattern_active), 8'd0);
      checkOutput("midrst_frame_cnt", bus.frame_cnt, 8'd0);
      checkOutput("midrst_colors_out", 8'(bus.colors_out), 8'd0);
      reset = 1'b0;
      bus.video_on = 1'b0;
      tick();
      checkOutput("blank_colors_out", 8'(bus.colors_out), 8'd0);
      bus.video_on = 1'b1;
      tick();
      checkOutput("solid_colors_out", 8'(bus.colors_out), 8'h02);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
